key_debounce: RTL

- Upstream conditioning stage for the kit's four push buttons.
- Synchronises raw active-low KEY inputs, debounces each key independently, and presents a clean active-low key vector. That vector feeds the 4-to-2 priority encoder stage directly as its KEY input.
- Also produces one-cycle press/release event pulses and an any-key-down flag for downstream counters and FSMs.

---
 rtl/key_debounce.sv | 85 ++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser and stability-counter debouncer for active-low buttons.
// Produces clean levels, one-cycle press/release pulses and an any-key-down flag.
module key_debounce #(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] KEY_CLEAN,
   output logic [N_KEYS-1:0] PRESS,
   output logic [N_KEYS-1:0] RELEASE,
   output logic              ANY_DOWN
);

   typedef enum logic [1:0] {
      STABLE,
      PENDING,
      ACCEPT
   } key_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] sync2;
   logic [CNT_W-1:0]  cnt      [N_KEYS];
   logic [CNT_W-1:0]  cnt_next [N_KEYS];
   key_state_t        state    [N_KEYS];
   logic [N_KEYS-1:0] clean_next;
   logic [N_KEYS-1:0] press_next;
   logic [N_KEYS-1:0] release_next;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1     <= '1;
         sync2     <= '1;
         KEY_CLEAN <= '1;
         PRESS     <= '0;
         RELEASE   <= '0;
         ANY_DOWN  <= 1'b0;
         for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1     <= KEY;
         sync2     <= sync1;
         KEY_CLEAN <= clean_next;
         PRESS     <= press_next;
         RELEASE   <= release_next;
         // ANY_DOWN follows the next clean value so it moves on the same edge.
         ANY_DOWN  <= ~&clean_next;
         for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   always_comb begin
      clean_next   = KEY_CLEAN;
      press_next   = '0;
      release_next = '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         cnt_next[i] = '0;
         if (sync2[i] == KEY_CLEAN[i]) begin
            state[i] = STABLE;
         end else if (cnt[i] == CNT_MAX) begin
            state[i] = ACCEPT;
         end else begin
            state[i] = PENDING;
         end

         case (state[i])
            PENDING: cnt_next[i] = cnt[i] + CNT_W'(1);
            ACCEPT: begin
               clean_next[i]   = sync2[i];
               press_next[i]   = ~sync2[i];
               release_next[i] = sync2[i];
            end
            default: cnt_next[i] = '0;
         endcase
      end
   end

endmodule
